// File: rtl/regr_point_gate.sv
// -----------------------------------------------------------------------------
// regr_point_gate
//
// Purpose:
//   Front end for the linear-regression stage. Scans one frame of the
//   per-pixel mask stream and forwards the (x, y) coordinates of qualifying
//   pixels as single-cycle valid pulses. A pixel qualifies when it is masked,
//   lies inside the active area, sits on the decimation grid, and the per-frame
//   point cap has not been reached. After the frame's last active pixel, one
//   tabulate pulse is issued (only if at least one point was forwarded).
//   Further frames are then held off until the regression reports a result or
//   a timeout expires.
//
// Ports:
//   clk_in              system clock
//   rst_in              synchronous active-high reset (shared with regression)
//   hcount_in[10:0]     current pixel column
//   vcount_in[9:0]      current pixel row
//   mask_in             pixel passes the colour threshold
//   enable_in           allow collection of a new frame
//   regr_valid_in       regression result valid (one-cycle pulse)
//   x_out[10:0]         forwarded point x (held between pulses)
//   y_out[9:0]          forwarded point y (held between pulses)
//   valid_out           x_out/y_out valid for one cycle
//   tabulate_out        one-cycle request to compute the fit
//   busy_out            high whenever the gate is not idle
//   point_count_out     points forwarded in the last completed frame
//   low_conf_out        last completed frame had fewer than MIN_POINTS points
//   timeout_out         last wait for a result ended by timeout
//   frames_skipped_out  frame starts ignored while waiting (saturating)
// -----------------------------------------------------------------------------
module regr_point_gate #(
    parameter int H_ACTIVE       = 1024,
    parameter int V_ACTIVE       = 768,
    parameter int SKIP_LOG2      = 1,
    parameter int MAX_POINTS     = 65535,
    parameter int MIN_POINTS     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        mask_in,
    input  logic        enable_in,
    input  logic        regr_valid_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        tabulate_out,
    output logic        busy_out,
    output logic [15:0] point_count_out,
    output logic        low_conf_out,
    output logic        timeout_out,
    output logic [7:0]  frames_skipped_out
);

    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [10:0]     H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]      V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [15:0]     MAX_P   = 16'(MAX_POINTS);
    localparam logic [15:0]     MIN_P   = 16'(MIN_POINTS);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_TAB,
        S_WAIT_RES
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [15:0]    r_count;
    logic [TW-1:0]  r_timer;
    logic [10:0]    r_x;
    logic [9:0]     r_y;
    logic           r_valid;
    logic           r_tab;
    logic [15:0]    r_point_count;
    logic           r_low_conf;
    logic           r_timeout;
    logic [7:0]     r_skipped;

    logic           w_fs;
    logic           w_lp;
    logic           w_pix_ok;
    logic           w_dec_ok;
    logic           w_start;
    logic           w_timeout_hit;
    logic [15:0]    w_count_base;
    logic           w_accept;
    logic [10:0]    w_h_low;
    logic [9:0]     w_v_low;

    // Decimation: gather the low SKIP_LOG2 bits of each count; any set bit
    // puts the pixel off the sampling grid.
    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_hdec
            assign w_h_low[gi] = (gi < SKIP_LOG2) ? hcount_in[gi] : 1'b0;
        end
        for (gi = 0; gi < 10; gi++) begin : g_vdec
            assign w_v_low[gi] = (gi < SKIP_LOG2) ? vcount_in[gi] : 1'b0;
        end
    endgenerate

    assign w_dec_ok = ~(|w_h_low) && ~(|w_v_low);
    assign w_fs     = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign w_lp     = (hcount_in == H_LAST) && (vcount_in == V_LAST);
    assign w_pix_ok = mask_in && (hcount_in <= H_LAST) && (vcount_in <= V_LAST) && w_dec_ok;

    // Next-state logic.
    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fs && enable_in) begin
                    w_start      = 1'b1;
                    // A degenerate one-pixel frame is both FS and LP.
                    w_state_next = w_lp ? S_FLUSH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_lp) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Never ask the regression to fit an empty point set.
                w_state_next = (r_count == 16'd0) ? S_IDLE : S_TAB;
            end
            S_TAB: begin
                w_state_next = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (regr_valid_in) begin
                    w_state_next = S_IDLE;
                end else if (r_timer >= TO_LAST) begin
                    w_state_next  = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The frame-start pixel is judged against a freshly cleared count, so it
    // can be accepted in the same cycle the gate leaves IDLE.
    assign w_count_base = w_start ? 16'd0 : r_count;
    assign w_accept     = (w_start || (r_state == S_COLLECT)) && w_pix_ok && (w_count_base < MAX_P);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count       <= 16'd0;
            r_timer       <= '0;
            r_x           <= 11'd0;
            r_y           <= 10'd0;
            r_valid       <= 1'b0;
            r_tab         <= 1'b0;
            r_point_count <= 16'd0;
            r_low_conf    <= 1'b0;
            r_timeout     <= 1'b0;
            r_skipped     <= 8'd0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_x <= hcount_in;
                r_y <= vcount_in;
            end

            if (w_start) begin
                r_count <= w_accept ? 16'd1 : 16'd0;
            end else if (w_accept) begin
                r_count <= r_count + 16'd1;
            end

            // Registered so the pulse lands one cycle after FLUSH, which is
            // always after the last possible valid_out of the frame.
            r_tab <= (r_state == S_FLUSH) && (r_count != 16'd0);

            if (r_state == S_FLUSH) begin
                r_point_count <= r_count;
                r_low_conf    <= (r_count < MIN_P);
            end

            // The timer starts at 1 so that it counts cycles since the
            // tabulate pulse; the gate is idle TIMEOUT_CYCLES after it.
            if (r_state == S_TAB) begin
                r_timer   <= TW'(1);
                r_timeout <= 1'b0;
            end else if (r_state == S_WAIT_RES) begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end

            if ((r_state == S_WAIT_RES) && w_fs && (r_skipped != 8'hFF)) begin
                r_skipped <= r_skipped + 8'd1;
            end
        end
    end

    assign x_out              = r_x;
    assign y_out              = r_y;
    assign valid_out          = r_valid;
    assign tabulate_out       = r_tab;
    assign busy_out           = (r_state != S_IDLE);
    assign point_count_out    = r_point_count;
    assign low_conf_out       = r_low_conf;
    assign timeout_out        = r_timeout;
    assign frames_skipped_out = r_skipped;

endmodule

// File: tb/tb_regr_point_gate.sv
// -----------------------------------------------------------------------------
// tb_regr_point_gate
//
// Small-frame bench for regr_point_gate (17x9 active inside a 20x11 raster,
// decimation by 2, cap of 4 points, 16-cycle timeout). Frames are described by
// a table of masked pixels (with the hand-decided accept outcome) and a table
// of per-frame expectations. Accepted pixels push their expected coordinates
// and arrival cycle into a scoreboard that a negedge monitor pops on every
// valid_out. Hand-written sequences cover the skipped-frame hold-off and a
// reset in the middle of collection.
// -----------------------------------------------------------------------------
module tb_regr_point_gate;

    localparam int H_ACTIVE = 17;
    localparam int V_ACTIVE = 9;
    localparam int H_TOTAL  = 20;
    localparam int V_TOTAL  = 11;
    localparam int N_FRAMES = 8;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        mask_in;
    logic        enable_in;
    logic        regr_valid_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        tabulate_out;
    logic        busy_out;
    logic [15:0] point_count_out;
    logic        low_conf_out;
    logic        timeout_out;
    logic [7:0]  frames_skipped_out;

    always #5 clk = ~clk;

    regr_point_gate #(
        .H_ACTIVE       (H_ACTIVE),
        .V_ACTIVE       (V_ACTIVE),
        .SKIP_LOG2      (1),
        .MAX_POINTS     (4),
        .MIN_POINTS     (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst_in),
        .hcount_in          (hcount_in),
        .vcount_in          (vcount_in),
        .mask_in            (mask_in),
        .enable_in          (enable_in),
        .regr_valid_in      (regr_valid_in),
        .x_out              (x_out),
        .y_out              (y_out),
        .valid_out          (valid_out),
        .tabulate_out       (tabulate_out),
        .busy_out           (busy_out),
        .point_count_out    (point_count_out),
        .low_conf_out       (low_conf_out),
        .timeout_out        (timeout_out),
        .frames_skipped_out (frames_skipped_out)
    );

    typedef struct {
        int c;
        int x;
        int y;
    } exp_t;

    typedef struct {
        int f;
        int x;
        int y;
        int acc;
    } pt_t;

    // Field order: en, stop, resp, exp_cnt, exp_low, exp_tab, chk_to, chk_clr
    typedef struct {
        int en;       // enable_in level for the frame
        int stop;     // stop after LP and run the skipped-frame sequence
        int resp;     // regr_valid_in this many cycles after tabulate (0: none)
        int exp_cnt;
        int exp_low;
        int exp_tab;
        int chk_to;   // check timeout timing
        int chk_clr;  // check timeout_out cleared by this tabulate
    } frm_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   lp_cyc = -1;
    int   tab_cnt = 0;
    int   tab_cyc = -100;
    int   overlap = 0;
    bit   hist_busy [8192];
    bit   hist_to   [8192];
    exp_t sb [$];
    pt_t  pts [$];
    frm_t fv [N_FRAMES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gap();
        hcount_in     = 11'(H_TOTAL - 1);
        vcount_in     = 10'(V_TOTAL - 1);
        mask_in       = 1'b0;
        regr_valid_in = 1'b0;
    endtask

    task automatic drive_pix(input int h, input int v, input bit m, input bit a);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        mask_in   = m;
        if (a) sb.push_back('{cyc + 1, h, v});
        if (h == H_ACTIVE - 1 && v == V_ACTIVE - 1) lp_cyc = cyc;
        step();
    endtask

    task automatic lookup(input int f, input int h, input int v, output bit m, output bit a);
        m = 1'b0;
        a = 1'b0;
        foreach (pts[k]) begin
            if (pts[k].f == f && pts[k].x == h && pts[k].y == v) begin
                m = 1'b1;
                a = (pts[k].acc != 0);
            end
        end
    endtask

    task automatic drive_frame(input int f);
        bit m;
        bit a;
        lp_cyc    = -1;
        enable_in = (fv[f].en != 0);
        for (int v = 0; v < V_TOTAL; v++) begin
            for (int h = 0; h < H_TOTAL; h++) begin
                lookup(f, h, v, m, a);
                regr_valid_in = (lp_cyc >= 0) && (fv[f].resp > 0) && (cyc == lp_cyc + 2 + fv[f].resp);
                drive_pix(h, v, m, a);
                if (fv[f].stop != 0 && lp_cyc >= 0) begin
                    set_gap();
                    return;
                end
            end
        end
        set_gap();
    endtask

    // Two frame starts arrive while waiting for a result, then the result.
    task automatic skip_seq();
        set_gap();
        step();                       // FLUSH
        step();                       // TAB
        hcount_in = 11'd0; vcount_in = 10'd0;
        step();                       // FS while waiting
        set_gap();
        step();
        hcount_in = 11'd0; vcount_in = 10'd0;
        step();                       // second FS while waiting
        set_gap();
        chk("skip_busy_waiting", int'(busy_out), 1);
        regr_valid_in = 1'b1;
        step();
        regr_valid_in = 1'b0;
        step();
        chk("skip_frames_skipped", int'(frames_skipped_out), 2);
        chk("skip_busy_after_result", int'(busy_out), 0);
        $display("skip sequence: frames_skipped=%0d busy=%0d", frames_skipped_out, busy_out);
    endtask

    task automatic run_frame(input int f);
        int tab_before;
        int t;
        tab_before = tab_cnt;
        drive_frame(f);
        if (fv[f].stop != 0) skip_seq();
        set_gap();
        repeat (5) step();
        chk($sformatf("f%0d_points_pending", f), sb.size(), 0);
        chk($sformatf("f%0d_tab_pulses", f), tab_cnt - tab_before, fv[f].exp_tab);
        if (fv[f].exp_tab != 0)
            chk($sformatf("f%0d_tab_cycle", f), tab_cyc, lp_cyc + 2);
        chk($sformatf("f%0d_point_count", f), int'(point_count_out), fv[f].exp_cnt);
        chk($sformatf("f%0d_low_conf", f), int'(low_conf_out), fv[f].exp_low);
        chk($sformatf("f%0d_busy_end", f), int'(busy_out), 0);
        t = lp_cyc + 2;
        if (fv[f].chk_to != 0) begin
            chk($sformatf("f%0d_busy_tab+15", f), int'(hist_busy[t + 15]), 1);
            chk($sformatf("f%0d_timeout_tab+15", f), int'(hist_to[t + 15]), 0);
            chk($sformatf("f%0d_busy_tab+16", f), int'(hist_busy[t + 16]), 0);
            chk($sformatf("f%0d_timeout_tab+16", f), int'(hist_to[t + 16]), 1);
        end
        if (fv[f].chk_clr != 0) begin
            chk($sformatf("f%0d_timeout_held", f), int'(hist_to[t - 1]), 1);
            chk($sformatf("f%0d_timeout_cleared", f), int'(hist_to[t + 1]), 0);
        end
        $display("frame %0d: count=%0d low=%0d tabs=%0d timeout=%0d", f, point_count_out,
                 low_conf_out, tab_cnt - tab_before, timeout_out);
    endtask

    // Reset lands after three accepted points of a frame.
    task automatic reset_seq();
        int tab_before;
        int h;
        int v;
        bit m;
        bit a;
        tab_before = tab_cnt;
        enable_in  = 1'b1;
        for (int p = 0; p < 2 * H_TOTAL + 6; p++) begin
            h = p % H_TOTAL;
            v = p / H_TOTAL;
            m = (h == 0 && v == 0) || (h == 2 && v == 2) || (h == 4 && v == 2);
            a = m;
            drive_pix(h, v, m, a);
        end
        hcount_in = 11'd6; vcount_in = 10'd2; mask_in = 1'b0;
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_tabulate_out", int'(tabulate_out), 0);
        chk("rst_busy_out", int'(busy_out), 0);
        chk("rst_point_count", int'(point_count_out), 0);
        chk("rst_low_conf", int'(low_conf_out), 0);
        chk("rst_timeout", int'(timeout_out), 0);
        chk("rst_frames_skipped", int'(frames_skipped_out), 0);
        for (int p = 2 * H_TOTAL + 7; p < H_TOTAL * V_TOTAL; p++) begin
            h = p % H_TOTAL;
            v = p / H_TOTAL;
            m = (h == 8 && v == 4) || (h == 16 && v == 8);
            drive_pix(h, v, m, 1'b0);
        end
        set_gap();
        repeat (5) step();
        chk("rst_points_pending", sb.size(), 0);
        chk("rst_no_tabulate", tab_cnt - tab_before, 0);
        chk("rst_busy_after", int'(busy_out), 0);
        chk("rst_count_after", int'(point_count_out), 0);
        $display("reset sequence: tabs=%0d busy=%0d", tab_cnt - tab_before, busy_out);
    endtask

    // Output monitor and scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            hist_busy[cyc % 8192] = busy_out;
            hist_to[cyc % 8192]   = timeout_out;
            if (valid_out && tabulate_out) overlap++;
            if (tabulate_out) begin
                tab_cnt++;
                tab_cyc = cyc;
                $display("tabulate at cycle %0d", cyc);
            end
            if (valid_out) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_point got (%0d,%0d) at cycle %0d expected none",
                             x_out, y_out, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.c != cyc || e.x != int'(x_out) || e.y != int'(y_out)) begin
                        errors++;
                        $display("FAIL point got (%0d,%0d)@%0d expected (%0d,%0d)@%0d",
                                 x_out, y_out, cyc, e.x, e.y, e.c);
                    end else begin
                        $display("point (%0d,%0d) at cycle %0d", x_out, y_out, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // frame 0: range and decimation rejects
        pts.push_back('{0, 2, 2, 1});
        pts.push_back('{0, 3, 2, 0});
        pts.push_back('{0, 2, 3, 0});
        pts.push_back('{0, 18, 4, 0});
        pts.push_back('{0, 4, 6, 1});
        // frame 1: empty mask
        // frame 2: frame-start pixel and last pixel both accepted
        pts.push_back('{2, 0, 0, 1});
        pts.push_back('{2, 18, 4, 0});
        pts.push_back('{2, 15, 8, 0});
        pts.push_back('{2, 16, 8, 1});
        // frame 3: ten candidates, cap of four
        pts.push_back('{3, 0, 2, 1});
        pts.push_back('{3, 2, 2, 1});
        pts.push_back('{3, 4, 2, 1});
        pts.push_back('{3, 6, 2, 1});
        pts.push_back('{3, 8, 2, 0});
        pts.push_back('{3, 10, 2, 0});
        pts.push_back('{3, 0, 4, 0});
        pts.push_back('{3, 2, 4, 0});
        pts.push_back('{3, 4, 4, 0});
        pts.push_back('{3, 6, 4, 0});
        // frame 4: no result, timeout
        pts.push_back('{4, 6, 6, 1});
        // frame 5: exactly MIN_POINTS points
        pts.push_back('{5, 8, 0, 1});
        pts.push_back('{5, 4, 4, 1});
        pts.push_back('{5, 10, 8, 1});
        // frame 6: enable low, nothing collected
        pts.push_back('{6, 2, 2, 0});
        // frame 7: after reset
        pts.push_back('{7, 12, 4, 1});

        fv[0] = '{1, 0, 3, 2, 1, 1, 0, 0};
        fv[1] = '{1, 0, 0, 0, 1, 0, 0, 0};
        fv[2] = '{1, 0, 3, 2, 1, 1, 0, 0};
        fv[3] = '{1, 1, 0, 4, 0, 1, 0, 0};
        fv[4] = '{1, 0, 0, 1, 1, 1, 1, 0};
        fv[5] = '{1, 0, 3, 3, 0, 1, 0, 1};
        fv[6] = '{0, 0, 0, 3, 0, 0, 0, 0};
        fv[7] = '{1, 0, 3, 1, 1, 1, 0, 0};

        rst_in    = 1'b1;
        enable_in = 1'b1;
        set_gap();
        repeat (3) step();
        chk("init_valid_out", int'(valid_out), 0);
        chk("init_tabulate_out", int'(tabulate_out), 0);
        chk("init_busy_out", int'(busy_out), 0);
        chk("init_point_count", int'(point_count_out), 0);
        chk("init_x_out", int'(x_out), 0);
        chk("init_frames_skipped", int'(frames_skipped_out), 0);
        chk("init_timeout", int'(timeout_out), 0);
        rst_in = 1'b0;
        step();

        for (int f = 0; f < 7; f++) run_frame(f);
        reset_seq();
        run_frame(7);

        chk("valid_tab_overlap", overlap, 0);
        chk("final_frames_skipped", int'(frames_skipped_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regr_point_gate.md
Name: regr_point_gate

Overview:
- Upstream feeder for the linear-regression stage. Scans the per-pixel mask stream of one video frame and emits the (x, y) coordinates of qualifying pixels as single-cycle valid pulses.
- Applies ROI bounds, decimation and a point cap, then issues exactly one tabulate pulse after the frame's last active pixel.
- Holds off further frames until the regression reports its result or a timeout expires.
- Guarantees that the point valid and the tabulate pulse are never asserted in the same cycle, and that the regression is never asked to tabulate zero points.

Parameters:
- H_ACTIVE, 1024, active pixels per line; last active column is H_ACTIVE-1.
- V_ACTIVE, 768, active lines per frame; last active line is V_ACTIVE-1.
- SKIP_LOG2, 1, decimation: accept only pixels with hcount and vcount both multiples of 2^SKIP_LOG2 (0 = no decimation).
- MAX_POINTS, 65535, cap on points forwarded per frame (≤ 65535).
- MIN_POINTS, 8, below this count the result is flagged low-confidence.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for a regression result after tabulate.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; shared with the regression stage.
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current pixel row.
- mask_in  input  1  pixel passes the colour threshold.
- enable_in  input  1  allow collection of a new frame.
- regr_valid_in  input  1  regression result valid (one-cycle pulse).
- x_out  output  11  point x coordinate.
- y_out  output  10  point y coordinate.
- valid_out  output  1  x_out/y_out valid for one cycle.
- tabulate_out  output  1  one-cycle request to compute the fit.
- busy_out  output  1  high whenever state ≠ IDLE.
- point_count_out  output  16  points forwarded in the last completed frame.
- low_conf_out  output  1  last frame count < MIN_POINTS.
- timeout_out  output  1  last wait ended by timeout.
- frames_skipped_out  output  8  frame starts ignored while waiting (saturating).

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset: every output is 0, internal point counter and timer are 0, state = IDLE. Reset mid-operation abandons the frame with no tabulate; the regression is cleared by the same rst_in.
- Frame start (FS): hcount_in==0 && vcount_in==0. Last pixel (LP): hcount_in==H_ACTIVE-1 && vcount_in==V_ACTIVE-1.
- States:
  - IDLE: on FS with enable_in=1, clear the internal count and go to COLLECT. The FS pixel itself is eligible for acceptance.
  - COLLECT: a pixel is accepted when all hold: mask_in=1; hcount_in<H_ACTIVE; vcount_in<V_ACTIVE; low SKIP_LOG2 bits of both counts are 0; count<MAX_POINTS. An accepted pixel at cycle N gives registered x_out/y_out and valid_out=1 at cycle N+1, and count increments. enable_in is ignored until the frame ends. On LP (the accept test still applies to that pixel) go to FLUSH.
  - FLUSH (one cycle): latch point_count_out=count and low_conf_out=(count<MIN_POINTS).
    - If count==0: go to IDLE, no tabulate.
    - Else: go to TAB.
  - TAB: tabulate_out=1 for exactly one cycle (cycle N+2 relative to LP at N); clear timer and timeout_out; go to WAIT_RES.
  - WAIT_RES:
    - regr_valid_in=1 → IDLE.
    - Each FS seen here increments frames_skipped_out, saturating at 255.
    - Timer increments each cycle. When it reaches TIMEOUT_CYCLES without a result, set timeout_out=1 (held until the next TAB) and go to IDLE.
    - regr_valid_in arriving in any state other than WAIT_RES is ignored.
- valid_out is 0 in all cycles except the cycle after an accepted pixel. valid_out and tabulate_out are never high together.
- x_out/y_out hold their last value when valid_out=0.
- A mid-frame start (first FS seen with vcount_in≠0 history) is not special-cased: collection always begins at FS.
- frames_skipped_out clears only on reset.

Test Plan:
- SKIP_LOG2=0; mask at (10,20), (30,40), (50,60) → three valid_out pulses, each one cycle after its pixel, with exact coordinates; single tabulate_out two cycles after (1023,767); point_count_out=3; low_conf_out=1.
- All-zero mask frame → no valid_out, no tabulate_out; point_count_out=0; returns to IDLE; next FS starts collection.
- SKIP_LOG2=1; mask on (1023,767) and (1022,766) → only (1022,766) accepted (1023 is odd); tabulate_out fires two cycles after LP; valid_out and tabulate_out never overlap.
- MAX_POINTS=4; ten masked pixels → exactly four valid_out; point_count_out=4. Hold regr_valid_in low across two FS → frames_skipped_out=2. Then pulse regr_valid_in → IDLE, and the next FS collects.
- TIMEOUT_CYCLES=16; no result after tabulate → timeout_out=1 and busy_out=0 sixteen cycles after TAB; timeout_out clears at the next tabulate.
- rst_in asserted mid-COLLECT after five accepted points → all outputs 0 the next cycle, no tabulate issued, next FS collects normally.
